// File: rtl/pipeline_fetch_queue.sv
// Fetch stage: owns the program counter, issues one read per cycle to a
// synchronous (1-cycle latency) instruction memory, and buffers the returned
// {pc, instruction} pairs in a DEPTH-entry queue feeding decode. A redirect
// from execute flushes the queue and drops any fetch still in flight.
module pipeline_fetch_queue #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter int unsigned           DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned           PC_STEP     = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic [ADDR_WIDTH-1:0]        imemAddress,
    output logic                         imemRequest,
    input  logic [INSTR_WIDTH-1:0]       imemData,
    input  logic                         jumpEnabled,
    input  logic [ADDR_WIDTH-1:0]        jumpValue,
    input  logic                         stallOnDecode,
    output logic                         outValid,
    output logic [ADDR_WIDTH-1:0]        outPc,
    output logic [INSTR_WIDTH-1:0]       outInstruction,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned           PTR_W      = $clog2(DEPTH);
    localparam int unsigned           CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]        DEPTH_C    = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP_C     = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(STEP_C - ADDR_WIDTH'(1));

    logic [ADDR_WIDTH-1:0]  fetchPc;
    logic [ADDR_WIDTH-1:0]  inFlightPc;
    logic                   inFlight;

    logic [ADDR_WIDTH-1:0]  pcQueue    [DEPTH];
    logic [INSTR_WIDTH-1:0] instrQueue [DEPTH];
    logic [PTR_W-1:0]       headPtr;
    logic [PTR_W-1:0]       tailPtr;
    logic [CNT_W-1:0]       count;

    logic                   issue;
    logic                   enqueue;
    logic                   dequeue;
    logic                   notEmpty;

    // Issue/enqueue/dequeue decisions. A read is only issued when a slot is
    // guaranteed for its response, counting the one already in flight.
    always_comb begin
        notEmpty = (count != '0);
        issue    = !reset && !jumpEnabled &&
                   (({1'b0, count} + {{CNT_W{1'b0}}, inFlight}) < DEPTH_C);
        enqueue  = inFlight && !jumpEnabled;
        dequeue  = notEmpty && !stallOnDecode && !jumpEnabled;
    end

    assign imemRequest    = issue;
    assign imemAddress    = fetchPc;
    assign outValid       = notEmpty;
    assign outPc          = notEmpty ? pcQueue[headPtr]    : '0;
    assign outInstruction = notEmpty ? instrQueue[headPtr] : '0;
    assign occupancy      = count;

    // Program counter, in-flight tracking and queue pointers; reset beats flush beats normal flow.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetchPc    <= RESET_PC;
            inFlight   <= 1'b0;
            inFlightPc <= '0;
            headPtr    <= '0;
            tailPtr    <= '0;
            count      <= '0;
        end else if (jumpEnabled) begin
            fetchPc    <= jumpValue & ALIGN_MASK;
            inFlight   <= 1'b0;
            headPtr    <= '0;
            tailPtr    <= '0;
            count      <= '0;
        end else begin
            inFlight <= issue;
            if (issue) begin
                fetchPc    <= fetchPc + STEP_C;
                inFlightPc <= fetchPc;
            end
            if (enqueue) begin
                tailPtr <= tailPtr + PTR_W'(1);
            end
            if (dequeue) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            case ({enqueue, dequeue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: the returning read lands in the tail slot unless dropped.
    always_ff @(posedge clock) begin
        if (!reset && enqueue) begin
            pcQueue[tailPtr]    <= inFlightPc;
            instrQueue[tailPtr] <= imemData;
        end
    end

endmodule
